// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

  // Controller states: INIT walks every entry once after reset, READY serves traffic.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEFAULT_DW    = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Widest data word the init helper can produce; callers slice it down to DW.
  localparam int MAX_DW = 64;

  // Power-up contents of entry idx: the index itself, zero-extended here and
  // truncated to DW by the caller.
  function automatic logic [MAX_DW-1:0] init_value(input logic [31:0] idx);
    return MAX_DW'(idx);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for in-flight producers, with a per-read-port
// lookup that treats a same-cycle write-back as already resolved.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_pending
);

  logic [DEPTH-1:0] pending;

  // Set on issue, clear on write-back; a set to the same register wins because
  // the newer producer is still outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (active) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set_en && set_addr == AW'(i) && !(ZERO_REG != 0 && i == 0)) begin
          pending[i] <= 1'b1;
        end else if (clr_en && clr_addr == AW'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
    logic [AW-1:0] ra;
    assign ra            = rd_addr[k*AW +: AW];
    assign rd_pending[k] = active && pending[ra] && !(clr_en && clr_addr == ra);
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, one write port
// with write-through bypass, optional hardwired-zero register 0, a
// self-sequencing init pass (entry i <= i) after reset, and a pending
// scoreboard for operands whose producer has not written back. DW <= 64.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DW       = DEFAULT_DW,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_RD*AW-1:0] r_addr,
  output logic [NUM_RD*DW-1:0] r_data,
  output logic [NUM_RD-1:0]    r_pending,
  input  logic                 write_en,
  input  logic [AW-1:0]        w_addr,
  input  logic [DW-1:0]        w_data,
  input  logic                 sb_set_en,
  input  logic [AW-1:0]        sb_set_addr,
  output logic                 init_busy
);

  state_t            state;
  logic [AW-1:0]     init_ptr;
  logic [DW-1:0]     mem [DEPTH];
  logic [MAX_DW-1:0] init_word;
  logic              ready;
  logic              wr_ok;

  assign ready     = (state == READY);
  assign init_busy = !ready;
  assign init_word = init_value(32'(init_ptr));
  assign wr_ok     = ready && write_en && !(ZERO_REG != 0 && w_addr == '0);

  // Init sequencer: walk init_ptr over every entry once, then hand over to READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
    end else if (state == INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == AW'(DEPTH - 1)) begin
        state <= READY;
      end
    end
  end

  // Storage write port: init pass during INIT, ordinary writes in READY.
  // NOTE: the array has no reset branch; the init pass rewrites every entry,
  // which keeps it mappable onto plain RAM/flop arrays without a reset net.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[init_ptr] <= init_word[DW-1:0];
      end else if (wr_ok) begin
        mem[w_addr] <= w_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    assign ra = r_addr[k*AW +: AW];

    // Read mux: blanked during INIT, then zero-reg, bypass, storage in priority order.
    // NOTE: rd gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
      rd = '0;
      if (!ready) begin
        rd = '0;
      end else if (ZERO_REG != 0 && ra == '0) begin
        rd = '0;
      end else if (write_en && w_addr == ra) begin
        rd = w_data;
      end else begin
        rd = mem[ra];
      end
    end

    assign r_data[k*DW +: DW] = rd;
  end

  reg_scoreboard #(
    .DEPTH   (DEPTH),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .active    (ready),
    .set_en    (sb_set_en),
    .set_addr  (sb_set_addr),
    .clr_en    (write_en),
    .clr_addr  (w_addr),
    .rd_addr   (r_addr),
    .rd_pending(r_pending)
  );

endmodule
